// File: rtl/seg_scan_driver_pkg.sv
// Shared definitions for the display path: mode encodings, segment constants,
// the per-frame snapshot record and the slot-to-anode mapping.
package seg_scan_driver_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER   = 2'b00,
        MODE_UNUSED    = 2'b01,
        MODE_ALARM     = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef struct packed {
        logic [3:0] left_ten;
        logic [3:0] left_one;
        logic [3:0] right_ten;
        logic [3:0] right_one;
        mode_e      mode;
    } snap_t;

    // Slot 0 is the leftmost digit, driven by an_n[3].
    function automatic logic [3:0] slot_anode(input logic [1:0] slot);
        logic [3:0] an;
        case (slot)
            2'd0:    an = 4'h7;
            2'd1:    an = 4'hB;
            2'd2:    an = 4'hD;
            2'd3:    an = 4'hE;
            default: an = AN_OFF;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// BCD to active-low 7-segment decoder, {g,f,e,d,c,b,a}; non-decimal codes show a dash.
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Segment lookup for one digit.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed common-anode display driver with per-frame snapshot,
// guard blanking and mode-dependent separator. Option: LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 4,
    parameter int HALF_SEC_DIV = 25000000
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic [3:0] left_ten,
    input  logic [3:0] left_one,
    input  logic [3:0] right_ten,
    input  logic [3:0] right_one,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HALF_SEC_DIV > 1) ? $clog2(HALF_SEC_DIV) : 1;

    logic [PW-1:0] presc_r;
    logic [1:0]    slot_r;
    logic [HW-1:0] half_r;
    logic          blink_r;
    logic          started_r;
    snap_t         snap_r;

    logic          presc_last_s;
    logic          half_last_s;
    logic          frame_start_s;
    logic [3:0]    digit_s;
    logic [6:0]    dec_seg_s;
    logic [6:0]    seg_nxt_s;
    logic [3:0]    an_nxt_s;
    logic          dp_nxt_s;

    assign presc_last_s  = (presc_r == PW'(SCAN_DIV - 1));
    assign half_last_s   = (half_r == HW'(HALF_SEC_DIV - 1));
    // A frame begins on the 3->0 slot advance, or on the first enabled cycle out of reset.
    assign frame_start_s = en & (~started_r | (presc_last_s & (slot_r == 2'd3)));

    // Prescaler, slot index, blink timebase and frame snapshot; all hold while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r   <= '0;
            slot_r    <= 2'd0;
            half_r    <= '0;
            blink_r   <= 1'b0;
            started_r <= 1'b0;
            snap_r    <= '0;
        end else if (en) begin
            started_r <= 1'b1;
            presc_r   <= presc_last_s ? '0 : presc_r + 1'b1;
            if (presc_last_s) begin
                slot_r <= slot_r + 2'd1;
            end
            half_r <= half_last_s ? '0 : half_r + 1'b1;
            if (half_last_s) begin
                blink_r <= ~blink_r;
            end
            if (frame_start_s) begin
                snap_r <= '{left_ten:  left_ten,
                            left_one:  left_one,
                            right_ten: right_ten,
                            right_one: right_one,
                            mode:      mode_e'(mode)};
            end
        end
    end

    // Select the snapshot digit for the active slot.
    always_comb begin
        digit_s = snap_r.right_one;
        case (slot_r)
            2'd0:    digit_s = snap_r.left_ten;
            2'd1:    digit_s = snap_r.left_one;
            2'd2:    digit_s = snap_r.right_ten;
            2'd3:    digit_s = snap_r.right_one;
            default: digit_s = snap_r.right_one;
        endcase
    end

    bcd_to_seg u_dec (
        .bcd   (digit_s),
        .seg_n (dec_seg_s)
    );

    // Next output values: blank during guard or when disabled, else the active digit.
    always_comb begin
        seg_nxt_s = SEG_BLANK;
        an_nxt_s  = AN_OFF;
        dp_nxt_s  = 1'b1;
        if (en && (presc_r >= PW'(GUARD))) begin
            an_nxt_s = slot_anode(slot_r);
`ifdef LEADING_ZERO_BLANK_EN
            if ((slot_r == 2'd0) && (snap_r.left_ten == 4'd0) &&
                ((snap_r.mode == MODE_COUNTER) || (snap_r.mode == MODE_ALARM))) begin
                seg_nxt_s = SEG_BLANK;
            end else begin
                seg_nxt_s = dec_seg_s;
            end
`else
            seg_nxt_s = dec_seg_s;
`endif
            // The separator sits after the second digit.
            if (slot_r == 2'd1) begin
                case (snap_r.mode)
                    MODE_STOPWATCH: dp_nxt_s = 1'b0;
                    MODE_ALARM:     dp_nxt_s = 1'b0;
                    MODE_COUNTER:   dp_nxt_s = ~blink_r;
                    default:        dp_nxt_s = 1'b1;
                endcase
            end else begin
                dp_nxt_s = 1'b1;
            end
        end else begin
            seg_nxt_s = SEG_BLANK;
            an_nxt_s  = AN_OFF;
            dp_nxt_s  = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg_n      <= seg_nxt_s;
            dp_n       <= dp_nxt_s;
            an_n       <= an_nxt_s;
            frame_tick <= frame_start_s;
        end
    end

endmodule
